// File: rtl/sd_otf_pkg.sv
// rtl/sd_otf_pkg.sv - signed-digit encodings and converter state shared by the online operators
package sd_otf_pkg;

    // Radix-2 signed-digit codes carried on two-bit digit streams.
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b10;
    localparam logic [1:0] SD_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } otf_state_t;

endpackage

// File: rtl/sd_otf_converter_step.sv
// rtl/sd_otf_converter_step.sv - one on-the-fly conversion step (Q/QM append of a signed digit)
//
// Ports:
//   q, qm     current Q register and QM = Q - 1 ulp
//   digit     signed digit code (illegal code behaves as zero)
//   q_next    Q after appending the digit
//   qm_next   QM after appending the digit
//   illegal   digit carried the illegal code
module sd_otf_step
    import sd_otf_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next,
    output logic         illegal
);

    // Appending -1 borrows from the higher digits, which QM already holds,
    // so every case is a pure shift-and-append with no carry chain.
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        illegal = (digit == SD_ILL);
        case (digit)
            SD_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            SD_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: begin
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/sd_otf_converter.sv
// rtl/sd_otf_converter.sv - MSD-first signed-digit stream to two's-complement word converter
//
// Ports:
//   clk         system clock
//   asyn_reset  asynchronous active-low reset
//   enable      stream enable; all state holds while low
//   start       begin a conversion (honoured only in IDLE or DONE)
//   q_value     incoming signed digit
//   q_word      result, value = q_word * 2^-N_DIGITS
//   valid       one-cycle pulse while a fresh q_word is presented
//   busy        skipping online-delay digits or collecting result digits
//   code_err    sticky flag: illegal digit code consumed during collection
module sd_otf_converter
    import sd_otf_pkg::*;
#(
    parameter int N_DIGITS     = 16,
    parameter int ONLINE_DELAY = 3
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                enable,
    input  logic                start,
    input  logic [1:0]          q_value,
    output logic [N_DIGITS:0]   q_word,
    output logic                valid,
    output logic                busy,
    output logic                code_err
);

    localparam int W   = N_DIGITS + 1;
    localparam int DCW = $clog2(N_DIGITS + 1);

    localparam logic [DCW-1:0] DIG_LAST  = DCW'(N_DIGITS - 1);
    localparam logic [2:0]     SKIP_LAST = (ONLINE_DELAY > 0) ? 3'(ONLINE_DELAY - 1) : 3'd0;
    localparam otf_state_t     FIRST_STATE = (ONLINE_DELAY > 0) ? SKIP : COLLECT;

    otf_state_t     state;
    otf_state_t     state_next;
    logic [2:0]     skip_cnt;
    logic [DCW-1:0] dig_cnt;
    logic [W-1:0]   q_reg;
    logic [W-1:0]   qm_reg;
    logic [W-1:0]   q_step;
    logic [W-1:0]   qm_step;
    logic           step_illegal;
    logic           start_take;
    logic           consume;

    assign start_take = enable && start && ((state == IDLE) || (state == DONE));
    assign consume    = enable && (state == COLLECT);

    sd_otf_step #(.W(W)) u_step (
        .q       (q_reg),
        .qm      (qm_reg),
        .digit   (q_value),
        .q_next  (q_step),
        .qm_next (qm_step),
        .illegal (step_illegal)
    );

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                IDLE:    if (start) state_next = FIRST_STATE;
                SKIP:    if (skip_cnt == SKIP_LAST) state_next = COLLECT;
                COLLECT: if (dig_cnt == DIG_LAST) state_next = DONE;
                DONE:    state_next = start ? FIRST_STATE : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // q_word is loaded on the edge that consumes the last digit so that it is
    // already stable during the DONE cycle in which valid is shown.
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            q_reg    <= '0;
            qm_reg   <= '1;
            skip_cnt <= '0;
            dig_cnt  <= '0;
            q_word   <= '0;
            code_err <= 1'b0;
        end else if (start_take) begin
            q_reg    <= '0;
            qm_reg   <= '1;
            skip_cnt <= '0;
            dig_cnt  <= '0;
            code_err <= 1'b0;
        end else begin
            if (enable && (state == SKIP)) begin
                skip_cnt <= skip_cnt + 3'd1;
            end
            if (consume) begin
                q_reg   <= q_step;
                qm_reg  <= qm_step;
                dig_cnt <= dig_cnt + DCW'(1);
                if (step_illegal) begin
                    code_err <= 1'b1;
                end
                if (dig_cnt == DIG_LAST) begin
                    q_word <= q_step;
                end
            end
        end
    end

    // Gating with enable keeps valid low in a stalled DONE cycle; the pulse
    // then appears in the first enabled cycle.
    assign valid = (state == DONE) && enable;
    assign busy  = (state == SKIP) || (state == COLLECT);

endmodule

// File: tb/tb_sd_otf_converter.sv
// tb/tb_sd_otf_converter.sv - self-checking bench for sd_otf_converter
module tb_sd_otf_converter;
    import sd_otf_pkg::*;

    typedef logic [1:0] seq_t [0:39];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_en, s_start;
    logic [1:0]  s_q;
    logic [4:0]  s_qw;
    logic        s_valid, s_busy, s_cerr;
    logic        d_en, d_start;
    logic [1:0]  d_q;
    logic [16:0] d_qw;
    logic        d_valid, d_busy, d_cerr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sd_otf_converter #(.N_DIGITS(4), .ONLINE_DELAY(0)) dut_s (
        .clk(clk), .asyn_reset(rst_n), .enable(s_en), .start(s_start), .q_value(s_q),
        .q_word(s_qw), .valid(s_valid), .busy(s_busy), .code_err(s_cerr)
    );

    sd_otf_converter #(.N_DIGITS(16), .ONLINE_DELAY(3)) dut_d (
        .clk(clk), .asyn_reset(rst_n), .enable(d_en), .start(d_start), .q_value(d_q),
        .q_word(d_qw), .valid(d_valid), .busy(d_busy), .code_err(d_cerr)
    );

    // Reference: the collected digits read as an integer sum d_i * 2^(n-1-i),
    // reduced to n+1 bits of two's complement.
    function automatic logic [16:0] model_word(input int n, input seq_t d, input int off);
        longint v = 0;
        longint mask;
        for (int i = 0; i < n; i++) begin
            v = v * 2;
            if (d[off + i] == SD_POS) v = v + 1;
            else if (d[off + i] == SD_NEG) v = v - 1;
        end
        mask = (longint'(1) <<< (n + 1)) - 1;
        return 17'(v & mask);
    endfunction

    function automatic logic model_err(input int n, input seq_t d, input int off);
        logic e = 1'b0;
        for (int i = 0; i < n; i++) if (d[off + i] == SD_ILL) e = 1'b1;
        return e;
    endfunction

    function automatic seq_t mk4(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] e);
        seq_t s = '{default: 2'b00};
        s[0] = a; s[1] = b; s[2] = c; s[3] = e;
        return s;
    endfunction

    function automatic logic [1:0] rnd_sd();
        int r = $urandom_range(0, 7);
        if (r < 3) return SD_POS;
        if (r < 6) return SD_NEG;
        if (r == 6) return SD_ZERO;
        return SD_ILL;
    endfunction

    task automatic set_in(input bit sel, input logic en, input logic st, input logic [1:0] d);
        if (sel) begin d_en = en; d_start = st; d_q = d; end
        else begin s_en = en; s_start = st; s_q = d; end
    endtask

    // Called at a negedge. Asserts start, feeds n_tot stream digits (skip +
    // collect) under the chosen enable pattern, and returns at the negedge
    // where valid is seen. lat counts cycles from the start cycle to valid.
    task automatic run_conv(input bit sel, input int n_tot, input seq_t seq, input int stall_mode,
                            input int mid_start_at, output logic [16:0] qw, output logic cerr,
                            output logic cerr0, output int lat, output int stalls,
                            output bit found, output bit busy_ok);
        int i = 0;
        bit tog = 1'b1;
        logic en, st;
        logic [1:0] dg;
        lat = 0; stalls = 0; found = 1'b0; busy_ok = 1'b1; qw = '0; cerr = 1'b0; cerr0 = 1'b0;
        set_in(sel, 1'b1, 1'b1, 2'($urandom));
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            lat++;
            if (sel ? d_valid : s_valid) begin
                found = 1'b1;
                qw = sel ? d_qw : {12'b0, s_qw};
                cerr = sel ? d_cerr : s_cerr;
                break;
            end
            if (c == 0) cerr0 = sel ? d_cerr : s_cerr;
            if (!(sel ? d_busy : s_busy)) busy_ok = 1'b0;
            st = (mid_start_at >= 0) && (i == mid_start_at);
            if (i < n_tot) begin
                case (stall_mode)
                    1: begin en = tog; tog = !tog; end
                    2: en = ($urandom_range(0, 3) != 0);
                    default: en = 1'b1;
                endcase
                if (en) begin dg = seq[i]; i++; end
                else begin dg = 2'($urandom); stalls++; end
            end else begin
                en = 1'b1;
                dg = 2'($urandom);
            end
            set_in(sel, en, st, dg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 2'b00);
        set_in(1'b1, 1'b1, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        vectors++; if (s_qw !== 5'h0) begin miscompares++; $display("FAIL reset_qword_s got=%0h exp=0", s_qw); end
        vectors++; if (d_qw !== 17'h0) begin miscompares++; $display("FAIL reset_qword_d got=%0h exp=0", d_qw); end
        vectors++; if ({s_valid, s_busy, s_cerr} !== 3'b000) begin miscompares++; $display("FAIL reset_flags_s got=%b exp=000", {s_valid, s_busy, s_cerr}); end
        vectors++; if ({d_valid, d_busy, d_cerr} !== 3'b000) begin miscompares++; $display("FAIL reset_flags_d got=%b exp=000", {d_valid, d_busy, d_cerr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_vectors();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        run_conv(1'b0, 4, mk4(SD_POS, SD_ZERO, SD_NEG, SD_POS), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h07) begin miscompares++; $display("FAIL small_7_16 got=%0h found=%0d exp=07", qw, f); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL small_latency got=%0d exp=5", lat); end
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL small_code_err got=%b exp=0", ce); end
        vectors++; if (!bo) begin miscompares++; $display("FAIL small_busy got=0 exp=1"); end
        @(negedge clk);
        vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("FAIL valid_pulse got=%b exp=0", s_valid); end
        vectors++; if (s_qw !== 5'h07) begin miscompares++; $display("FAIL qword_hold got=%0h exp=07", s_qw); end
        run_conv(1'b0, 4, mk4(SD_NEG, SD_NEG, SD_NEG, SD_NEG), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h11) begin miscompares++; $display("FAIL small_m15_16 got=%0h found=%0d exp=11", qw, f); end
        @(negedge clk);
        run_conv(1'b0, 4, mk4(SD_ZERO, SD_NEG, SD_POS, SD_POS), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h1f) begin miscompares++; $display("FAIL small_m1_16 got=%0h found=%0d exp=1f", qw, f); end
        @(negedge clk);
    endtask

    task automatic test_default_skip();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        seq_t s = '{default: 2'b00};
        s[0] = SD_ILL; s[1] = SD_POS; s[2] = SD_NEG; s[3] = SD_POS;
        run_conv(1'b1, 19, s, 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h08000) begin miscompares++; $display("FAIL default_half got=%0h found=%0d exp=08000", qw, f); end
        vectors++; if (lat !== 20) begin miscompares++; $display("FAIL default_latency got=%0d exp=20", lat); end
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL default_skip_ill got=%b exp=0", ce); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        run_conv(1'b0, 4, mk4(SD_POS, SD_ZERO, SD_NEG, SD_POS), 1, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h07) begin miscompares++; $display("FAIL stall_qword got=%0h found=%0d exp=07", qw, f); end
        vectors++; if (st == 0 || lat !== 5 + st) begin miscompares++; $display("FAIL stall_latency got=%0d exp=%0d", lat, 5 + st); end
        vectors++; if (!bo) begin miscompares++; $display("FAIL stall_busy got=0 exp=1"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        set_in(1'b0, 1'b1, 1'b1, 2'b00);
        @(negedge clk); set_in(1'b0, 1'b1, 1'b0, SD_POS);
        @(negedge clk); set_in(1'b0, 1'b1, 1'b0, SD_NEG);
        @(negedge clk);
        vectors++; if (s_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before got=%b exp=1", s_busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (s_qw !== 5'h0) begin miscompares++; $display("FAIL midrst_qword got=%0h exp=0", s_qw); end
        vectors++; if ({s_valid, s_busy} !== 2'b00) begin miscompares++; $display("FAIL midrst_flags got=%b exp=00", {s_valid, s_busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(1'b0, 4, mk4(SD_POS, SD_POS, SD_ZERO, SD_ZERO), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h0c) begin miscompares++; $display("FAIL midrst_new got=%0h found=%0d exp=0c", qw, f); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        run_conv(1'b0, 4, mk4(SD_POS, SD_ILL, SD_ZERO, SD_ZERO), 0, 2, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h08) begin miscompares++; $display("FAIL ill_qword got=%0h found=%0d exp=08", qw, f); end
        vectors++; if (ce !== 1'b1) begin miscompares++; $display("FAIL ill_code_err got=%b exp=1", ce); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ill_busy_start got=%0d exp=5", lat); end
        @(negedge clk); @(negedge clk);
        vectors++; if (s_cerr !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got=%b exp=1", s_cerr); end
        run_conv(1'b0, 4, mk4(SD_POS, SD_POS, SD_POS, SD_POS), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (ce0 !== 1'b0) begin miscompares++; $display("FAIL ill_clear got=%b exp=0", ce0); end
        vectors++; if (!f || qw !== 17'h0f) begin miscompares++; $display("FAIL ill_next got=%0h found=%0d exp=0f", qw, f); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [16:0] qw; logic ce, ce0; int lat, st; bit f, bo;
        run_conv(1'b0, 4, mk4(SD_POS, SD_ZERO, SD_ZERO, SD_ZERO), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h08) begin miscompares++; $display("FAIL b2b_first got=%0h found=%0d exp=08", qw, f); end
        run_conv(1'b0, 4, mk4(SD_NEG, SD_ZERO, SD_ZERO, SD_ZERO), 0, -1, qw, ce, ce0, lat, st, f, bo);
        vectors++; if (!f || qw !== 17'h18) begin miscompares++; $display("FAIL b2b_second got=%0h found=%0d exp=18", qw, f); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [16:0] qw, exp_w; logic ce, ce0, exp_e; int lat, st; bit f, bo;
        seq_t s;
        for (int k = 0; k < 20; k++) begin
            s = '{default: 2'b00};
            for (int j = 0; j < 4; j++) s[j] = rnd_sd();
            exp_w = model_word(4, s, 0);
            exp_e = model_err(4, s, 0);
            run_conv(1'b0, 4, s, 2, -1, qw, ce, ce0, lat, st, f, bo);
            vectors++; if (!f || qw !== exp_w || ce !== exp_e || lat !== 5 + st) begin
                miscompares++;
                $display("FAIL rand_small got=%0h/%b/%0d exp=%0h/%b/%0d", qw, ce, lat, exp_w, exp_e, 5 + st);
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            s = '{default: 2'b00};
            for (int j = 0; j < 19; j++) s[j] = rnd_sd();
            exp_w = model_word(16, s, 3);
            exp_e = model_err(16, s, 3);
            run_conv(1'b1, 19, s, 2, -1, qw, ce, ce0, lat, st, f, bo);
            vectors++; if (!f || qw !== exp_w || ce !== exp_e || lat !== 20 + st) begin
                miscompares++;
                $display("FAIL rand_default got=%0h/%b/%0d exp=%0h/%b/%0d", qw, ce, lat, exp_w, exp_e, 20 + st);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_small_vectors();
        test_default_skip();
        test_stall();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_otf_converter.md
Name: sd_otf_converter

Overview:
- Receiving end of the divider's MSD-first signed-digit quotient stream (`q_value`).
- Discards the divider's online-delay digits, then collects N_DIGITS radix-2 signed digits.
- Converts them on the fly into a two's-complement fractional word using Q/QM registers, so no carry-propagate addition is needed.
- Sits directly after Divider_v2 (and other online operators), sharing its clock, reset and enable.

Parameters:
- N_DIGITS, 16, number of result digits collected after the skip phase (legal 2..32).
- ONLINE_DELAY, 3, leading stream digits discarded before collection (legal 0..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- asyn_reset  input  1  asynchronous, active-low reset.
- enable  input  1  global stream enable; a digit is consumed only in cycles with enable=1.
- start  input  1  begin a conversion; sampled only in IDLE or DONE.
- q_value  input  2  signed digit: 01=+1, 10=-1, 00=0, 11=illegal (treated as 0).
- q_word  output  N_DIGITS+1  two's-complement result, value = q_word * 2^-N_DIGITS.
- valid  output  1  one-cycle pulse when q_word is updated with a new result.
- busy  output  1  high in SKIP and COLLECT.
- code_err  output  1  sticky: an illegal code 11 was consumed in COLLECT; cleared by start.

Behaviour:
- Reset (asyn_reset=0, any time, including mid-conversion): state=IDLE, q_word=0, valid=0, busy=0, code_err=0, Q=0, QM=all ones, counters=0.
- States:
  - IDLE: start=1 -> SKIP if ONLINE_DELAY>0, else COLLECT. On that transition: Q<=0, QM<=all ones, counters<=0, code_err<=0.
  - SKIP: on each cycle with enable=1, skip_cnt++. When skip_cnt reaches ONLINE_DELAY-1 with enable=1 -> COLLECT. Digit values are ignored, including code 11.
  - COLLECT: on each cycle with enable=1, consume q_value and dig_cnt++. On the N_DIGITS-th consumed digit -> DONE.
  - DONE: lasts one cycle. q_word<=Q_final, valid=1. Next state is IDLE; if start=1 in DONE, go straight to SKIP/COLLECT instead.
- The digit on q_value in the start cycle is not consumed; the first consumed digit is sampled on the next enabled cycle.
- start while busy=1 is ignored.
- enable=0 freezes all state and counters (stall); valid is never asserted in a stalled cycle.
- On-the-fly step, registers N_DIGITS+1 bits wide, shift left by one and append a bit:
  - q=+1: Q<={Q,1}, QM<={Q,0}.
  - q=0: Q<={Q,0}, QM<={QM,1}.
  - q=-1: Q<={QM,1}, QM<={QM,0}.
  - MSBs shifted out are dropped.
  - Invariant: QM = Q - 1 ulp.
- Latency: valid asserts the cycle after the last consumed digit. From start with continuous enable, that is 1 + ONLINE_DELAY + N_DIGITS cycles.
- q_word holds its value until the next DONE. It is never cleared by start.
- Representable range: -(1 - 2^-N) .. +(1 - 2^-N). No overflow is possible for N_DIGITS digits.

Decomposition:
- Shared package holds:
  - digit encoding constants SD_POS=2'b01, SD_NEG=2'b10, SD_ZERO=2'b00, SD_ILL=2'b11;
  - state enum {IDLE, SKIP, COLLECT, DONE}.
- The same package is to be reused by the signed-digit serializer that feeds x_value/d_value.
- One natural sub-module: sd_otf_step (combinational: Q, QM, digit -> Q_next, QM_next, illegal flag).

Test Plan:
- N_DIGITS=4, ONLINE_DELAY=0, digits +1,0,-1,+1 continuous enable -> valid at cycle 5 after start, q_word=5'b00111 (7/16), code_err=0.
- N_DIGITS=4, ONLINE_DELAY=0, digits -1,-1,-1,-1 -> q_word=5'b10001 (-15/16). Then digits 0,-1,+1,+1 -> q_word=5'b11111 (-1/16).
- Defaults (16/3): three garbage digits 11,01,10 followed by +1 then fifteen 0 -> q_word=17'h08000 (+1/2), code_err=0.
- enable toggled 1,0,1,0 during the 4-digit case +1,0,-1,+1 -> same q_word=5'b00111; busy stays high and valid is delayed by exactly the number of stalled cycles.
- asyn_reset pulsed low after 2 collected digits -> outputs 0 immediately. A new start with digits +1,+1,0,0 -> q_word=5'b01100; the earlier partial digits have no effect.
- Illegal code 11 in COLLECT position 2 of +1,11,0,0 -> q_word=5'b01000 and code_err=1. The next start clears code_err; a second start during busy is ignored.
